// File: rtl/game_pkg.sv
// Shared types and constants for the game round timer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low seven-segment patterns for 0..9, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Control pulses and display/status outputs of the round timer.
interface game_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       bonus;
  logic [6:0] seg7_dig0;
  logic [6:0] seg7_dig1;
  logic [6:0] seg7_dig2;
  logic [9:0] secs;
  logic       running;
  logic       expired;
  logic       expired_pulse;

  modport master (
    output start, pause, bonus,
    input  seg7_dig0, seg7_dig1, seg7_dig2, secs, running, expired, expired_pulse
  );

  modport slave (
    input  start, pause, bonus,
    output seg7_dig0, seg7_dig1, seg7_dig2, secs, running, expired, expired_pulse
  );
endinterface

// File: rtl/seg7_bcd_decode.sv
// Combinational binary (0..999) to three active-low seven-segment digits.
module seg7_bcd_decode
  import game_pkg::*;
(
  input  logic [9:0] bin,
  output logic [6:0] dig0,
  output logic [6:0] dig1,
  output logic [6:0] dig2
);

  logic [11:0] bcd;
  logic [9:0]  sh;

  // Double-dabble: adjust each BCD nibble >=5 by +3, then shift in the next binary bit.
  always_comb begin
    bcd = '0;
    sh  = bin;
    for (int unsigned i = 0; i < 10; i++) begin
      for (int unsigned d = 0; d < 3; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) begin
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
      end
      bcd = {bcd[10:0], sh[9]};
      sh  = {sh[8:0], 1'b0};
    end
  end

  assign dig0 = seg_decode(bcd[3:0]);
  assign dig1 = seg_decode(bcd[7:4]);
  assign dig2 = seg_decode(bcd[11:8]);

endmodule

// File: rtl/game_timer_ctrl.sv
// Round countdown controller: IDLE/RUN/PAUSED/EXPIRED sequencing, seconds
// count with bonus and saturation, blinking expiry display, registered digits.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned START_SECS = 60,
  parameter int unsigned BONUS_SECS = 5,
  parameter int unsigned BLINK_DIV  = 12500000
) (
  input logic               clk,
  input logic               resetn,
  game_timer_ctrl_if.slave  bus
);

  localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned    BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [9:0]     START_VAL  = 10'(START_SECS);
  localparam logic [9:0]     SECS_MAX   = 10'd999;
  localparam logic [6:0]     RST_DIG0   = seg_decode(4'(START_SECS % 10));
  localparam logic [6:0]     RST_DIG1   = seg_decode(4'((START_SECS / 10) % 10));
  localparam logic [6:0]     RST_DIG2   = seg_decode(4'(START_SECS / 100));

  state_t          state;
  logic [PW-1:0]   presc;
  logic [BW-1:0]   blink_cnt;
  logic            blank;
  logic [9:0]      secs_q;
  logic            running_q;
  logic            expired_q;
  logic            pulse_q;
  logic [6:0]      dig0_q, dig1_q, dig2_q;
  logic [6:0]      dec0, dec1, dec2;
  logic            tick;
  logic            bonus_ok;
  logic [10:0]     sum;
  logic [9:0]      next_secs;

  seg7_bcd_decode u_dec (
    .bin  (secs_q),
    .dig0 (dec0),
    .dig1 (dec1),
    .dig2 (dec2)
  );

  // Tick detection and the saturating next-count computed at 11 bits.
  always_comb begin
    tick      = (state == RUN) && (presc == PRESC_LAST);
    bonus_ok  = bus.bonus && ((state == RUN) || (state == PAUSED));
    sum       = {1'b0, secs_q} - {10'd0, tick} + (bonus_ok ? 11'(BONUS_SECS) : 11'd0);
    next_secs = (sum > {1'b0, SECS_MAX}) ? SECS_MAX : sum[9:0];
  end

  // State machine, counters, status flags and registered display digits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      presc     <= '0;
      blink_cnt <= '0;
      blank     <= 1'b0;
      secs_q    <= START_VAL;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      dig0_q    <= RST_DIG0;
      dig1_q    <= RST_DIG1;
      dig2_q    <= RST_DIG2;
    end else begin
      pulse_q <= 1'b0;
      dig0_q  <= blank ? SEG_BLANK : dec0;
      dig1_q  <= blank ? SEG_BLANK : dec1;
      dig2_q  <= blank ? SEG_BLANK : dec2;
      if (bus.start) begin
        state     <= RUN;
        secs_q    <= START_VAL;
        presc     <= '0;
        blink_cnt <= '0;
        blank     <= 1'b0;
        running_q <= 1'b1;
        expired_q <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            // pause outranks tick/bonus: the prescaler holds so no tick is lost
            if (bus.pause) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              if (next_secs == 10'd0) begin
                secs_q    <= '0;
                state     <= EXPIRED;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                pulse_q   <= 1'b1;
              end else begin
                secs_q <= next_secs;
              end
            end
          end
          PAUSED: begin
            if (bus.pause) begin
              state     <= RUN;
              running_q <= 1'b1;
            end else if (bus.bonus) begin
              secs_q <= next_secs;
            end
          end
          EXPIRED: begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blank     <= ~blank;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.secs          = secs_q;
  assign bus.running       = running_q;
  assign bus.expired       = expired_q;
  assign bus.expired_pulse = pulse_q;
  assign bus.seg7_dig0     = dig0_q;
  assign bus.seg7_dig1     = dig1_q;
  assign bus.seg7_dig2     = dig2_q;

endmodule

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
Countdown-timer controller for the pancake game round. It sequences a seconds counter through idle, run, pause and expiry. It converts the count to three active-low seven-segment digit patterns that drive the on-screen digit renderer's seg7_dig0..2 inputs. It also supplies running/expired status to the game logic.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=2)
START_SECS, 60, round length loaded on start (1..999)
BONUS_SECS, 5, seconds added per bonus pulse (0..999)
BLINK_DIV, 12500000, clk cycles per blink half-period in EXPIRED (>=1)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse; (re)start round
pause  input  1  1-cycle pulse; toggle RUN/PAUSED
bonus  input  1  1-cycle pulse; add BONUS_SECS
seg7_dig0  output  7  ones digit, active low, bit0=a..bit6=g
seg7_dig1  output  7  tens digit, same encoding
seg7_dig2  output  7  hundreds digit, same encoding
secs  output  10  current count, binary 0..999
running  output  1  high in RUN
expired  output  1  high in EXPIRED
expired_pulse  output  1  1-cycle strobe on entry to EXPIRED

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on resetn. All state is flopped on the rising edge of clk.
- Reset values:
  - state=IDLE, secs=START_SECS, prescaler=0, blink counter=0, blank=0
  - running=0, expired=0, expired_pulse=0
  - seg7_dig* = decode of START_SECS (60 gives 7'h40, 7'h02, 7'h40).
- States: IDLE, RUN, PAUSED, EXPIRED. running=(state==RUN), expired=(state==EXPIRED); both are registered.
- Priority within a cycle: start > pause > (bonus and tick combined).
- start, any state:
  - secs<=START_SECS, prescaler<=0, blink state cleared, next state RUN.
  - pause and bonus in the same cycle are ignored.
- pause:
  - RUN->PAUSED, PAUSED->RUN.
  - Ignored in IDLE and EXPIRED.
  - The prescaler holds its value while PAUSED and resumes from it.
- Prescaler: counts only in RUN; at TICK_DIV-1 it wraps to 0 and asserts tick for that cycle.
- Count update in RUN (bonus also accepted in PAUSED):
  - next = min(secs - tick + (bonus ? BONUS_SECS : 0), 999).
  - Compute at 11 bits, then saturate.
  - bonus in IDLE or EXPIRED is ignored.
- Expiry: if in RUN and next==0, then secs<=0, state<=EXPIRED, and expired_pulse=1 for exactly that one registered cycle. A tick with bonus at secs=1 does not expire when BONUS_SECS>0.
- EXPIRED:
  - secs frozen at 0.
  - Blink counter toggles blank every BLINK_DIV cycles.
  - When blank=1 all digits are 7'h7F (all off); otherwise 7'h40 x3.
  - Only start leaves EXPIRED.
- Display path:
  - secs goes to binary-to-BCD (double-dabble, combinational), then per-digit decode, then registered outputs.
  - Latency: seg7_dig* reflect secs one cycle after secs updates.
  - No leading-zero blanking.
- Decode table, 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). BCD codes above 9 decode to 7'h7F; these are unreachable.
- Asserting resetn mid-round returns to IDLE immediately; no pending tick or pulse survives.

Decomposition:
- Shared package game_pkg:
  - state enum encoding (IDLE=0, RUN=1, PAUSED=2, EXPIRED=3)
  - SEG_BLANK=7'h7F
  - the 10-entry segment decode constant table
- Sub-module seg7_bcd_decode: 10-bit binary in; three 7-bit active-low patterns out; purely combinational.
- The controller instantiates seg7_bcd_decode once and registers its outputs with the blank mux.

Test Plan:
Bench parameters: TICK_DIV=4, START_SECS=3, BONUS_SECS=5, BLINK_DIV=2.
1. Reset, then release -> IDLE, secs=3, seg7_dig0=7'h30, dig1=dig2=7'h40, running=0, expired=0.
2. start pulse -> running=1 next cycle. secs goes 3->2->1->0, one step every 4 cycles. expired_pulse is high for 1 cycle on the step to 0. seg7_dig0 shows 24, 79, 40 with 1-cycle lag.
3. In EXPIRED, observe 8 cycles -> all digits alternate 7'h40 and 7'h7F every 2 cycles. bonus and pause have no effect. start reloads secs=3 in RUN.
4. RUN at secs=2, pause after 2 prescaler cycles, hold 10 cycles, pause again -> secs stays 2 while PAUSED. Next tick arrives exactly 2 cycles after resume.
5. Bonus coinciding with tick at secs=1 -> secs=5, no expiry. Repeated bonus from 997 -> saturates at 999, digits 7'h10 x3.
6. start, pause and bonus in the same cycle during PAUSED at secs=7 -> RUN with secs=3. Assert resetn low mid-RUN -> IDLE, secs=3, all status outputs low.
